load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between EX stage and word-only data memory; converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW
//  into word accesses. Loads: lane extract + sign/zero extend. Sub-word stores: read-modify-write
//  (memory writes whole words only). Checks alignment/range before any memory access.
// PARAMETERS
//  MEM_WORDS    64  words in data memory; byte addr >= MEM_WORDS*4 is out of range
//  CHECK_RANGE  1   1: flag out-of-range; 0: pass address unchecked (memory aliases)
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  reset      in   1   synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   unit idle, can accept
//  req_load   in   1   1=load, 0=store
//  req_funct3 in   3   RV32I width/sign field
//  req_addr   in   32  byte address (rs1+imm)
//  req_wdata  in   32  store data (rs2), low bits used for SB/SH
//  rsp_valid  out  1   result/completion available
//  rsp_ready  in   1   consumer accepts response
//  rsp_rdata  out  32  extended load data; 0 for stores and errors
//  rsp_err    out  2   00 ok, 01 misaligned, 10 out-of-range, 11 illegal funct3
//  mem_read   out  1   to memory read enable (memory outputs 0 when low)
//  mem_write  out  1   to memory write enable, sampled at rising edge
//  mem_addr   out  32  to memory address (word index = bits[7:2])
//  mem_wdata  out  32  to memory write word
//  mem_rdata  in   32  from memory, combinational w.r.t. mem_addr/mem_read
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1 after reset; rsp_valid/mem_read/mem_write=0; addr/data/err regs 0.
//  - States: IDLE, LOAD, ST_READ, ST_WRITE, RESP. Memory outputs decoded from registered state/regs only.
//  - IDLE: req_ready=1. On req_valid: latch load/funct3/addr/wdata. Error check, priority illegal >
//    misaligned > range: illegal = load f3 in {011,110,111} or store f3 not in {000,001,010};
//    misaligned = H with addr[0]!=0, W with addr[1:0]!=0; range = CHECK_RANGE && addr>=MEM_WORDS*4.
//    Error -> RESP with rsp_err set, rdata 0, no mem access. Else load->LOAD, SW->ST_WRITE
//    (merge word = wdata), SB/SH->ST_READ.
//  - LOAD: mem_read=1, mem_addr=addr_q; capture lane (byte addr[1:0], half addr[1]) extended per
//    funct3 (B/H sign, BU/HU zero, W as is) into rdata_q; -> RESP.
//  - ST_READ: mem_read=1; merge_q = mem_rdata with wdata_q[7:0] into byte lane addr[1:0] or
//    wdata_q[15:0] into half lane addr[1]; -> ST_WRITE.
//  - ST_WRITE: mem_write=1, mem_wdata=merge_q, mem_addr=addr_q, exactly one cycle; -> RESP.
//  - RESP: rsp_valid=1, outputs stable until rsp_ready; on rsp_ready -> IDLE. No new accept in RESP.
//  - Latency req accept -> rsp_valid: load 2 cycles, SW 2, SB/SH 3, error 1 (rsp_ready held 1).
//  - mem_read and mem_write never both high; mem_addr=0, mem_wdata=0 when neither asserted.
//  - Reset mid-op: return to IDLE next edge; a store in ST_READ is dropped with no write;
//    pending response discarded.
//  - Address passed unmodified (no truncation); bits[1:0] only select lanes.
// STRUCTURE
//  - lsu_pkg: funct3 constants (F3_B,F3_H,F3_W,F3_BU,F3_HU), rsp_err codes, state enum.
//  - Sub-module lsu_lane_align (combinational): extract+extend for loads, lane merge for stores;
//    shared by LOAD and ST_READ paths. FSM, request regs and error check stay in top.
// TESTING (bench pairs unit with a 64-word memory model, rsp_ready=1 unless noted)
//  - mem[1]=32'h8899_AABB; LB 0x7 -> rdata FFFF_FF88; LBU 0x7 -> 0000_0088; LH 0x4 -> FFFF_AABB;
//    LHU 0x6 -> 0000_8899; LW 0x4 -> 8899_AABB, rsp_valid 2 cycles after accept.
//  - mem[2]=1122_3344; SB 0x9 wdata=0xDEADBEEF -> mem[2]=1122_EF44, one mem_write pulse, rsp at +3;
//    SH 0xA wdata=0x0000_CAFE -> mem[2]=CAFE_EF44; SW 0x8 0x01020304 -> mem[2]=0102_0304, +2.
//  - LW 0x6 -> err 01, no mem_read/mem_write ever asserted; SH 0x3 -> err 01, memory unchanged;
//    load f3=011 -> err 11; LW 0x100 (MEM_WORDS=64) -> err 10, rdata 0.
//  - rsp_ready low 5 cycles in RESP: rsp_valid/rdata/err stable, req_ready=0, req_valid ignored.
//  - Assert reset during ST_READ of SB 0x1: no write, next cycle req_ready=1, rsp_valid=0, mem_* 0.
//  - Back-to-back: SB 0x0 0xAA then LW 0x0 -> load returns merged word (low byte AA).

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 encodings,
// response error codes, FSM states and the request-side error classifier.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ST_READ,
    S_ST_WRITE,
    S_RESP
  } lsu_state_e;

  // Illegal beats misaligned; the range check is layered on by the caller.
  function automatic lsu_err_e classify(input logic is_load, input logic [2:0] f3,
                                        input logic [1:0] lane);
    logic illegal;
    logic half;
    if (is_load) illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    else         illegal = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
    half = (f3 == F3_H) || (f3 == F3_HU);
    if (illegal)                         return ERR_ILLEGAL;
    else if (half && lane[0])            return ERR_MISALIGN;
    else if (f3 == F3_W && lane != 2'b00) return ERR_MISALIGN;
    else                                 return ERR_OK;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the EX stage and the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_load, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_load, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: extract+extend a memory word for loads, and merge
// store data into a memory word for sub-word read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    unique case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data = {24'h0, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data = {16'h0, half_v};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merge_word = word;
    if (funct3 == F3_B) begin
      merge_word[{lane, 3'b000} +: 8] = wdata[7:0];
    end else if (funct3 == F3_H) begin
      if (lane[1]) merge_word[31:16] = wdata[15:0];
      else         merge_word[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only data memory: checks requests,
// extracts/extends load lanes, and performs read-modify-write for SB/SH.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 64,
  parameter int unsigned CHECK_RANGE = 1
) (
  input  logic                clk,
  input  logic                reset,
  load_store_unit_if.slave    bus,
  output logic                mem_read,
  output logic                mem_write,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  lsu_state_e  state_q, state_d;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  lsu_err_e    err_q;
  lsu_err_e    err_d;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] merge_word;

  always_comb begin
    err_d = classify(bus.req_load, bus.req_funct3, bus.req_addr[1:0]);
    if (err_d == ERR_OK && CHECK_RANGE != 0 && {1'b0, bus.req_addr} >= ADDR_LIMIT)
      err_d = ERR_RANGE;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (err_d != ERR_OK)             state_d = S_RESP;
          else if (bus.req_load)           state_d = S_LOAD;
          else if (bus.req_funct3 == F3_W) state_d = S_ST_WRITE;
          else                             state_d = S_ST_READ;
        end
      end
      S_LOAD:     state_d = S_RESP;
      S_ST_READ:  state_d = S_ST_WRITE;
      S_ST_WRITE: state_d = S_RESP;
      S_RESP:     if (bus.rsp_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // merge_q is preloaded with the store data so SW can skip the read phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_OK;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        merge_q  <= bus.req_wdata;
        rdata_q  <= '0;
        err_q    <= err_d;
      end
      if (state_q == S_LOAD)    rdata_q <= load_data;
      if (state_q == S_ST_READ) merge_q <= merge_word;
    end
  end

  lsu_lane_align u_align (
    .funct3     (funct3_q),
    .lane       (addr_q[1:0]),
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  always_comb begin
    mem_read      = (state_q == S_LOAD) || (state_q == S_ST_READ);
    mem_write     = (state_q == S_ST_WRITE);
    mem_addr      = (mem_read || mem_write) ? addr_q : '0;
    mem_wdata     = mem_write ? merge_q : '0;
    bus.req_ready = (state_q == S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit paired with a 64-word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [64] = '{default: '0};
  logic        tb_we = 1'b0;
  logic [5:0]  tb_idx = '0;
  logic [31:0] tb_dat = '0;

  int n_applied = 0;
  int n_miss    = 0;
  int rd_cnt    = 0;
  int wr_cnt    = 0;
  int both_cnt  = 0;
  int idle_bad  = 0;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(64), .CHECK_RANGE(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : '0;

  always @(posedge clk) begin
    if (mem_read)  rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read && mem_write) both_cnt++;
    if (!mem_read && !mem_write && (mem_addr != 0 || mem_wdata != 0)) idle_bad++;
    if (mem_write)  mem[mem_addr[7:2]] <= mem_wdata;
    else if (tb_we) mem[tb_idx] <= tb_dat;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: act=%h req=%h", nm, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    tb_we = 1'b1; tb_idx = 6'(idx); tb_dat = val;
    @(posedge clk); #1;
    tb_we = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    int          chk_idx;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[$];

  // Starts at a negedge with the unit idle; ends at a negedge with it idle again.
  task automatic run_vec(input vec_t v);
    int lat = 0;
    bit got = 0;
    int rd0 = rd_cnt;
    int wr0 = wr_cnt;
    bus.req_valid = 1'b1; bus.req_load = v.ld; bus.req_funct3 = v.f3;
    bus.req_addr = v.addr; bus.req_wdata = v.wdata;
    while (!got && lat < 20) begin
      @(posedge clk); lat++;
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      if (bus.rsp_valid) got = 1;
    end
    check($sformatf("%s latency", v.name), 32'(lat), 32'(v.exp_lat));
    check($sformatf("%s rdata", v.name), bus.rsp_rdata, v.exp_rdata);
    check($sformatf("%s err", v.name), 32'(bus.rsp_err), 32'(v.exp_err));
    @(posedge clk); @(negedge clk);
    check($sformatf("%s ready after", v.name), 32'(bus.req_ready), 32'd1);
    check($sformatf("%s mem reads", v.name), 32'(rd_cnt - rd0), 32'(v.exp_rd));
    check($sformatf("%s mem writes", v.name), 32'(wr_cnt - wr0), 32'(v.exp_wr));
    if (v.chk_idx >= 0)
      check($sformatf("%s mem word", v.name), mem[v.chk_idx], v.exp_word);
  endtask

  initial begin
    int rd0;
    int wr0;
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;

    //          name     ld  f3      addr      wdata         rdata         err lat rd wr idx word
    vecs.push_back('{"LB7",   1, 3'b000, 32'h7,   32'h0,        32'hFFFF_FF88, 2'b00, 2, 1, 0, -1, 32'h0});
    vecs.push_back('{"LBU7",  1, 3'b100, 32'h7,   32'h0,        32'h0000_0088, 2'b00, 2, 1, 0, -1, 32'h0});
    vecs.push_back('{"LH4",   1, 3'b001, 32'h4,   32'h0,        32'hFFFF_AABB, 2'b00, 2, 1, 0, -1, 32'h0});
    vecs.push_back('{"LHU6",  1, 3'b101, 32'h6,   32'h0,        32'h0000_8899, 2'b00, 2, 1, 0, -1, 32'h0});
    vecs.push_back('{"LW4",   1, 3'b010, 32'h4,   32'h0,        32'h8899_AABB, 2'b00, 2, 1, 0, -1, 32'h0});
    vecs.push_back('{"SB9",   0, 3'b000, 32'h9,   32'hDEAD_BEEF, 32'h0,        2'b00, 3, 1, 1,  2, 32'h1122_EF44});
    vecs.push_back('{"SHA",   0, 3'b001, 32'hA,   32'h0000_CAFE, 32'h0,        2'b00, 3, 1, 1,  2, 32'hCAFE_EF44});
    vecs.push_back('{"SW8",   0, 3'b010, 32'h8,   32'h0102_0304, 32'h0,        2'b00, 2, 0, 1,  2, 32'h0102_0304});
    vecs.push_back('{"LW6",   1, 3'b010, 32'h6,   32'h0,        32'h0,         2'b01, 1, 0, 0, -1, 32'h0});
    vecs.push_back('{"SH3",   0, 3'b001, 32'h3,   32'hFFFF_FFFF, 32'h0,        2'b01, 1, 0, 0,  0, 32'h0});
    vecs.push_back('{"LF3",   1, 3'b011, 32'h0,   32'h0,        32'h0,         2'b11, 1, 0, 0, -1, 32'h0});
    vecs.push_back('{"SF3",   0, 3'b100, 32'h0,   32'h1234_5678, 32'h0,        2'b11, 1, 0, 0,  0, 32'h0});
    vecs.push_back('{"LF3pri",1, 3'b011, 32'h101, 32'h0,        32'h0,         2'b11, 1, 0, 0, -1, 32'h0});
    vecs.push_back('{"LHpri", 1, 3'b001, 32'h101, 32'h0,        32'h0,         2'b01, 1, 0, 0, -1, 32'h0});
    vecs.push_back('{"LW100", 1, 3'b010, 32'h100, 32'h0,        32'h0,         2'b10, 1, 0, 0, -1, 32'h0});
    vecs.push_back('{"LB100", 1, 3'b000, 32'h100, 32'h0,        32'h0,         2'b10, 1, 0, 0, -1, 32'h0});
    vecs.push_back('{"LBFF",  1, 3'b000, 32'hFF,  32'h0,        32'h0,         2'b00, 2, 1, 0, -1, 32'h0});

    @(negedge clk);
    poke(1, 32'h8899_AABB);
    poke(2, 32'h1122_3344);
    reset = 1'b0;

    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset mem_read", 32'(mem_read), 32'd0);
    check("reset mem_write", 32'(mem_write), 32'd0);
    check("reset mem_addr", mem_addr, 32'h0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Response held while rsp_ready is low; a pending request must not be taken.
    bus.rsp_ready = 1'b0;
    wr0 = wr_cnt;
    begin
      vec_t v;
      int lat = 0;
      v = vecs[4];
      bus.req_valid = 1'b1; bus.req_load = v.ld; bus.req_funct3 = v.f3;
      bus.req_addr = v.addr; bus.req_wdata = v.wdata;
      while (!bus.rsp_valid && lat < 20) begin
        @(posedge clk); lat++;
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
      end
      check("stall latency", 32'(lat), 32'd2);
    end
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = 1'b1; bus.req_load = 1'b0; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h0; bus.req_wdata = 32'hFFFF_FFFF;
      @(posedge clk); @(negedge clk);
      check($sformatf("stall%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("stall%0d rdata", k), bus.rsp_rdata, 32'h8899_AABB);
      check($sformatf("stall%0d err", k), 32'(bus.rsp_err), 32'd0);
      check($sformatf("stall%0d req_ready", k), 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("stall release rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("stall release req_ready", 32'(bus.req_ready), 32'd1);
    check("stall no write", 32'(wr_cnt - wr0), 32'd0);
    check("stall mem0", mem[0], 32'h0);

    // Reset while a byte store is in its read phase drops the store.
    wr0 = wr_cnt;
    bus.req_valid = 1'b1; bus.req_load = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h1; bus.req_wdata = 32'h0000_0077;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst st_read mem_read", 32'(mem_read), 32'd1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst mem_read", 32'(mem_read), 32'd0);
    check("rst mem_write", 32'(mem_write), 32'd0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); @(negedge clk);
    check("rst no write", 32'(wr_cnt - wr0), 32'd0);
    check("rst mem0", mem[0], 32'h0);

    // Back-to-back: the load must observe the freshly merged word.
    rd0 = rd_cnt;
    run_vec('{"SB0", 0, 3'b000, 32'h0, 32'h0000_00AA, 32'h0, 2'b00, 3, 1, 1, 0, 32'h0000_00AA});
    run_vec('{"LW0", 1, 3'b010, 32'h0, 32'h0, 32'h0000_00AA, 2'b00, 2, 1, 0, -1, 32'h0});
    check("b2b reads", 32'(rd_cnt - rd0), 32'd2);

    check("mem rd/wr exclusive", 32'(both_cnt), 32'd0);
    check("mem idle outputs zero", 32'(idle_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
